// File: rtl/mc_ctrl_exc.sv
// Multi-cycle MIPS control FSM; traps are funnelled through one EXC state that loads the exception vector.
// Optional feature: define CTRL_OVF_TRAP_EN to trap on signed overflow of ADD, SUB and ADDI.
module mc_ctrl_exc #(
    parameter int ALU_OP_W    = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CAUSE_W     = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         Inst_in,
    input  logic                zero,
    input  logic                overflow,
    input  logic                MIO_ready,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                IorD,
    output logic                CPU_MIO,
    output logic [ALU_OP_W-1:0] ALU_operation,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          RegDst,
    output logic [1:0]          MemtoReg,
    output logic [1:0]          PCSource,
    output logic                RegWrite,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                Branch,
    output logic                EPCWrite,
    output logic                CauseWrite,
    output logic [CAUSE_W-1:0]  cause_code,
    output logic [4:0]          state_out
);

    typedef enum logic [4:0] {
        S_IF     = 5'd0,  S_ID     = 5'd1,  S_MEM_EX = 5'd2,  S_MEM_RD = 5'd3,
        S_LW_WB  = 5'd4,  S_MEM_WR = 5'd5,  S_R_EXE  = 5'd6,  S_R_WB   = 5'd7,
        S_BR_EXE = 5'd8,  S_J      = 5'd9,  S_I_EXE  = 5'd10, S_I_WB   = 5'd11,
        S_LUI_WB = 5'd12, S_JR     = 5'd14, S_JAL    = 5'd15, S_EXC    = 5'd16
    } state_t;

    localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(4'b0000);
    localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(4'b0001);
    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(4'b0010);
    localparam logic [ALU_OP_W-1:0] ALU_XOR = ALU_OP_W'(4'b0011);
    localparam logic [ALU_OP_W-1:0] ALU_NOR = ALU_OP_W'(4'b0100);
    localparam logic [ALU_OP_W-1:0] ALU_SRL = ALU_OP_W'(4'b0101);
    localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(4'b0110);
    localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(4'b0111);
    localparam logic [ALU_OP_W-1:0] ALU_SLL = ALU_OP_W'(4'b1000);
    localparam logic [ALU_OP_W-1:0] ALU_SRA = ALU_OP_W'(4'b1001);

    localparam logic [CAUSE_W-1:0] CAUSE_OVF = CAUSE_W'(1);
    localparam logic [CAUSE_W-1:0] CAUSE_BUS = CAUSE_W'(2);
    localparam logic [CAUSE_W-1:0] CAUSE_ILL = CAUSE_W'(3);

    localparam int              CNT_W     = $clog2(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

`ifdef CTRL_OVF_TRAP_EN
    localparam bit OVF_TRAP_EN = 1'b1;
`else
    localparam bit OVF_TRAP_EN = 1'b0;
`endif

    typedef struct packed {
        logic                mem_read;
        logic                mem_write;
        logic                ir_write;
        logic                iord;
        logic                cpu_mio;
        logic [ALU_OP_W-1:0] alu_op;
        logic                alu_src_a;
        logic [1:0]          alu_src_b;
        logic [1:0]          reg_dst;
        logic [1:0]          mem_to_reg;
        logic [1:0]          pc_source;
        logic                reg_write;
        logic                pc_write;
        logic                pc_write_cond;
        logic                branch;
        logic                epc_write;
        logic                cause_write;
    } ctrl_t;

    // Fetch controls double as the reset value so the first cycle out of reset is a fetch.
    function automatic ctrl_t fetch_ctrl();
        ctrl_t c;
        c           = '0;
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = 2'b01;
        c.cpu_mio   = 1'b1;
        c.alu_op    = ALU_ADD;
        return c;
    endfunction

    state_t             state, state_nxt;
    ctrl_t              ctrl_q, ctrl_nxt;
    logic [CAUSE_W-1:0] cause_q, cause_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;

    logic [5:0]          opcode, funct;
    logic [ALU_OP_W-1:0] r_alu_op, i_alu_op;
    logic                r_legal, i_legal, r_arith, i_arith;
    logic                mem_timeout;

    assign opcode      = Inst_in[31:26];
    assign funct       = Inst_in[5:0];
    assign mem_timeout = !MIO_ready && (cnt_q == CNT_LIMIT);

    // Register fields and the zero flag are consumed by the datapath, not here.
    logic unused_inputs;
    assign unused_inputs = ^{zero, Inst_in[25:6]};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        r_alu_op = ALU_ADD;
        r_legal  = 1'b1;
        r_arith  = 1'b0;
        case (funct)
            6'b100000: begin r_alu_op = ALU_ADD; r_arith = 1'b1; end
            6'b100010: begin r_alu_op = ALU_SUB; r_arith = 1'b1; end
            6'b100100: r_alu_op = ALU_AND;
            6'b100101: r_alu_op = ALU_OR;
            6'b100110: r_alu_op = ALU_XOR;
            6'b100111: r_alu_op = ALU_NOR;
            6'b101010: r_alu_op = ALU_SLT;
            6'b000000: r_alu_op = ALU_SLL;
            6'b000010: r_alu_op = ALU_SRL;
            6'b000011: r_alu_op = ALU_SRA;
            default:   r_legal  = 1'b0;
        endcase

        i_alu_op = ALU_ADD;
        i_legal  = 1'b1;
        i_arith  = 1'b0;
        case (opcode)
            6'b001000: begin i_alu_op = ALU_ADD; i_arith = 1'b1; end
            6'b001100: i_alu_op = ALU_AND;
            6'b001101: i_alu_op = ALU_OR;
            6'b001110: i_alu_op = ALU_XOR;
            6'b001010: i_alu_op = ALU_SLT;
            default:   i_legal  = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cause_nxt = cause_q;
        case (state)
            S_IF, S_MEM_RD, S_MEM_WR: begin
                // A ready arriving on the limit cycle wins over the timeout.
                if (MIO_ready) begin
                    state_nxt = (state == S_IF)     ? S_ID :
                                (state == S_MEM_RD) ? S_LW_WB : S_IF;
                end else if (mem_timeout) begin
                    state_nxt = S_EXC;
                    cause_nxt = CAUSE_BUS;
                end
            end
            S_ID: begin
                if (opcode == 6'b000000 && funct == 6'b001000) state_nxt = S_JR;
                else if (opcode == 6'b000000 && r_legal)       state_nxt = S_R_EXE;
                else if (i_legal)                              state_nxt = S_I_EXE;
                else if (opcode == 6'b001111)                  state_nxt = S_LUI_WB;
                else if (opcode == 6'b100011 || opcode == 6'b101011) state_nxt = S_MEM_EX;
                else if (opcode == 6'b000100 || opcode == 6'b000101) state_nxt = S_BR_EXE;
                else if (opcode == 6'b000010)                  state_nxt = S_J;
                else if (opcode == 6'b000011)                  state_nxt = S_JAL;
                else begin
                    state_nxt = S_EXC;
                    cause_nxt = CAUSE_ILL;
                end
            end
            S_MEM_EX: state_nxt = (opcode == 6'b100011) ? S_MEM_RD : S_MEM_WR;
            S_R_EXE, S_I_EXE: begin
                if (OVF_TRAP_EN && overflow && ((state == S_R_EXE) ? r_arith : i_arith)) begin
                    state_nxt = S_EXC;
                    cause_nxt = CAUSE_OVF;
                end else begin
                    state_nxt = (state == S_R_EXE) ? S_R_WB : S_I_WB;
                end
            end
            default: state_nxt = S_IF;
        endcase

        if (state_nxt != state)                                   cnt_nxt = '0;
        else if (!MIO_ready && (state inside {S_IF, S_MEM_RD, S_MEM_WR})) cnt_nxt = cnt_q + 1'b1;
        else                                                      cnt_nxt = cnt_q;
    end

    // Outputs are decoded from the next state so they line up with state_out once registered.
    always_comb begin
        ctrl_nxt = '0;
        case (state_nxt)
            S_IF:     ctrl_nxt = fetch_ctrl();
            S_ID:     begin ctrl_nxt.alu_src_b = 2'b11; ctrl_nxt.alu_op = ALU_ADD; end
            S_MEM_EX: begin
                ctrl_nxt.alu_src_a = 1'b1;
                ctrl_nxt.alu_src_b = 2'b10;
                ctrl_nxt.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin ctrl_nxt.mem_read  = 1'b1; ctrl_nxt.iord = 1'b1; ctrl_nxt.cpu_mio = 1'b1; end
            S_MEM_WR: begin ctrl_nxt.mem_write = 1'b1; ctrl_nxt.iord = 1'b1; ctrl_nxt.cpu_mio = 1'b1; end
            S_LW_WB:  begin ctrl_nxt.reg_write = 1'b1; ctrl_nxt.mem_to_reg = 2'b01; end
            S_R_EXE:  begin ctrl_nxt.alu_src_a = 1'b1; ctrl_nxt.alu_op = r_alu_op; end
            S_R_WB:   begin ctrl_nxt.reg_write = 1'b1; ctrl_nxt.reg_dst = 2'b01; end
            S_I_EXE:  begin
                ctrl_nxt.alu_src_a = 1'b1;
                ctrl_nxt.alu_src_b = 2'b10;
                ctrl_nxt.alu_op    = i_alu_op;
            end
            S_I_WB:   ctrl_nxt.reg_write = 1'b1;
            S_LUI_WB: begin ctrl_nxt.reg_write = 1'b1; ctrl_nxt.mem_to_reg = 2'b10; end
            S_BR_EXE: begin
                ctrl_nxt.alu_src_a     = 1'b1;
                ctrl_nxt.alu_op        = ALU_SUB;
                ctrl_nxt.pc_write_cond = 1'b1;
                ctrl_nxt.pc_source     = 2'b01;
                ctrl_nxt.branch        = (opcode == 6'b000100);
            end
            S_J:      begin ctrl_nxt.pc_write = 1'b1; ctrl_nxt.pc_source = 2'b10; end
            // JR encodes rt=$0, so A + B passes rs straight through the ALU.
            S_JR:     begin
                ctrl_nxt.pc_write  = 1'b1;
                ctrl_nxt.alu_src_a = 1'b1;
                ctrl_nxt.alu_op    = ALU_ADD;
            end
            S_JAL:    begin
                ctrl_nxt.pc_write   = 1'b1;
                ctrl_nxt.pc_source  = 2'b10;
                ctrl_nxt.reg_write  = 1'b1;
                ctrl_nxt.reg_dst    = 2'b10;
                ctrl_nxt.mem_to_reg = 2'b11;
            end
            S_EXC:    begin
                ctrl_nxt.pc_write    = 1'b1;
                ctrl_nxt.pc_source   = 2'b11;
                ctrl_nxt.epc_write   = 1'b1;
                ctrl_nxt.cause_write = 1'b1;
            end
            default:  ctrl_nxt = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IF;
            ctrl_q  <= fetch_ctrl();
            cause_q <= '0;
            cnt_q   <= '0;
        end else begin
            state   <= state_nxt;
            ctrl_q  <= ctrl_nxt;
            cause_q <= cause_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    assign MemRead       = ctrl_q.mem_read;
    assign MemWrite      = ctrl_q.mem_write;
    assign IRWrite       = ctrl_q.ir_write;
    assign IorD          = ctrl_q.iord;
    assign CPU_MIO       = ctrl_q.cpu_mio;
    assign ALU_operation = ctrl_q.alu_op;
    assign ALUSrcA       = ctrl_q.alu_src_a;
    assign ALUSrcB       = ctrl_q.alu_src_b;
    assign RegDst        = ctrl_q.reg_dst;
    assign MemtoReg      = ctrl_q.mem_to_reg;
    assign PCSource      = ctrl_q.pc_source;
    assign RegWrite      = ctrl_q.reg_write;
    assign PCWrite       = ctrl_q.pc_write;
    assign PCWriteCond   = ctrl_q.pc_write_cond;
    assign Branch        = ctrl_q.branch;
    assign EPCWrite      = ctrl_q.epc_write;
    assign CauseWrite    = ctrl_q.cause_write;
    assign cause_code    = cause_q;
    assign state_out     = state;

endmodule

// File: tb/tb_mc_ctrl_exc.sv
// Directed bench for mc_ctrl_exc: per-cycle expectations are queued before each clock edge
// and popped/compared just after it.
module tb_mc_ctrl_exc;

    localparam int ALU_OP_W    = 4;
    localparam int MEM_TIMEOUT = 16;
    localparam int CAUSE_W     = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic [31:0]         Inst_in;
    logic                zero, overflow, MIO_ready;
    logic                MemRead, MemWrite, IRWrite, IorD, CPU_MIO;
    logic [ALU_OP_W-1:0] ALU_operation;
    logic                ALUSrcA;
    logic [1:0]          ALUSrcB, RegDst, MemtoReg, PCSource;
    logic                RegWrite, PCWrite, PCWriteCond, Branch, EPCWrite, CauseWrite;
    logic [CAUSE_W-1:0]  cause_code;
    logic [4:0]          state_out;

    mc_ctrl_exc #(.ALU_OP_W(ALU_OP_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CAUSE_W(CAUSE_W)) dut (
        .clk(clk), .reset(reset), .Inst_in(Inst_in), .zero(zero), .overflow(overflow),
        .MIO_ready(MIO_ready), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .IorD(IorD), .CPU_MIO(CPU_MIO), .ALU_operation(ALU_operation), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .RegDst(RegDst), .MemtoReg(MemtoReg), .PCSource(PCSource),
        .RegWrite(RegWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch),
        .EPCWrite(EPCWrite), .CauseWrite(CauseWrite), .cause_code(cause_code),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    typedef enum int {
        O_STATE, O_REGWRITE, O_REGDST, O_MEMTOREG, O_PCSRC, O_PCWRITE, O_PCWCOND, O_BRANCH,
        O_EPCW, O_CAUSEW, O_CAUSE, O_MEMREAD, O_MEMWRITE, O_IRWRITE, O_CPUMIO, O_IORD,
        O_ALUOP, O_ALUSRCA, O_ALUSRCB
    } obs_e;

    typedef struct {
        string       tag;
        obs_e        sel;
        logic [31:0] val;
    } item_t;

    item_t       sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [2:0]  exp_cause;

    function automatic logic [31:0] observe(input obs_e s);
        case (s)
            O_STATE:    return 32'(state_out);
            O_REGWRITE: return 32'(RegWrite);
            O_REGDST:   return 32'(RegDst);
            O_MEMTOREG: return 32'(MemtoReg);
            O_PCSRC:    return 32'(PCSource);
            O_PCWRITE:  return 32'(PCWrite);
            O_PCWCOND:  return 32'(PCWriteCond);
            O_BRANCH:   return 32'(Branch);
            O_EPCW:     return 32'(EPCWrite);
            O_CAUSEW:   return 32'(CauseWrite);
            O_CAUSE:    return 32'(cause_code);
            O_MEMREAD:  return 32'(MemRead);
            O_MEMWRITE: return 32'(MemWrite);
            O_IRWRITE:  return 32'(IRWrite);
            O_CPUMIO:   return 32'(CPU_MIO);
            O_IORD:     return 32'(IorD);
            O_ALUOP:    return 32'(ALU_operation);
            O_ALUSRCA:  return 32'(ALUSrcA);
            O_ALUSRCB:  return 32'(ALUSrcB);
            default:    return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_o(input string tag, input obs_e sel, input logic [31:0] val);
        item_t it;
        it.tag = tag;
        it.sel = sel;
        it.val = val;
        sb.push_back(it);
    endtask

    task automatic check();
        item_t       it;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            it  = sb.pop_front();
            obs = observe(it.sel);
            tests++;
            assert (obs === it.val) else begin
                fails++;
                $error("FAIL %s: observed %0h expected %0h", it.tag, obs, it.val);
            end
        end
    endtask

    task automatic step(input logic rdy, input logic ovf, input logic zr);
        MIO_ready = rdy;
        overflow  = ovf;
        zero      = zr;
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic expect_if(input string tag);
        expect_o({tag, ".state"}, O_STATE, 0);
        expect_o({tag, ".pcw"}, O_PCWRITE, 1);
        expect_o({tag, ".memrd"}, O_MEMREAD, 1);
        expect_o({tag, ".irw"}, O_IRWRITE, 1);
        expect_o({tag, ".regw"}, O_REGWRITE, 0);
        expect_o({tag, ".epcw"}, O_EPCW, 0);
        expect_o({tag, ".cause"}, O_CAUSE, 32'(exp_cause));
    endtask

    // Load IR contents and move IF -> ID with an immediate ready.
    task automatic fetch_decode(input string tag, input logic [31:0] inst);
        Inst_in = inst;
        expect_o({tag, ".id"}, O_STATE, 1);
        expect_o({tag, ".id_srcb"}, O_ALUSRCB, 3);
        expect_o({tag, ".id_srca"}, O_ALUSRCA, 0);
        step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic wait_mem_rd(input string tag);
        for (int i = 1; i < MEM_TIMEOUT; i++) begin
            expect_o({tag, ".wait"}, O_STATE, 3);
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        reset     = 1'b0;
        Inst_in   = '0;
        zero      = 1'b0;
        overflow  = 1'b0;
        MIO_ready = 1'b0;
        exp_cause = 3'd0;

        repeat (2) @(posedge clk);
        #1;
        expect_if("rst");
        expect_o("rst.srcb", O_ALUSRCB, 1);
        expect_o("rst.mio", O_CPUMIO, 1);
        expect_o("rst.alu", O_ALUOP, 4'b0010);
        check();
        reset = 1'b1;

        expect_o("if.hold", O_STATE, 0);
        step(1'b0, 1'b0, 1'b0);

        // add $3,$1,$2
        fetch_decode("add", 32'h0022_1820);
        expect_o("add.exe", O_STATE, 6);
        expect_o("add.exe_alu", O_ALUOP, 4'b0010);
        expect_o("add.exe_regw", O_REGWRITE, 0);
        step(1'b1, 1'b0, 1'b0);
        expect_o("add.wb", O_STATE, 7);
        expect_o("add.wb_regw", O_REGWRITE, 1);
        expect_o("add.wb_regdst", O_REGDST, 1);
        step(1'b1, 1'b0, 1'b0);
        expect_if("add.if");
        expect_o("add.if_regdst", O_REGDST, 0);
        step(1'b1, 1'b0, 1'b0);

        // and never traps even with the overflow flag raised
        fetch_decode("and", 32'h0022_1824);
        expect_o("and.exe_alu", O_ALUOP, 4'b0000);
        step(1'b1, 1'b0, 1'b0);
        expect_o("and.wb", O_STATE, 7);
        expect_o("and.wb_regw", O_REGWRITE, 1);
        step(1'b1, 1'b1, 1'b0);
        expect_if("and.if");
        step(1'b1, 1'b0, 1'b0);

        // sra $3,$2,2
        fetch_decode("sra", 32'h0002_1883);
        expect_o("sra.exe", O_STATE, 6);
        expect_o("sra.exe_alu", O_ALUOP, 4'b1001);
        step(1'b1, 1'b0, 1'b0);
        expect_o("sra.wb", O_STATE, 7);
        step(1'b1, 1'b0, 1'b0);
        expect_if("sra.if");
        step(1'b1, 1'b0, 1'b0);

        // addi with overflow during I_EXE
        fetch_decode("addi", 32'h2022_0005);
        expect_o("addi.exe", O_STATE, 10);
        expect_o("addi.exe_srcb", O_ALUSRCB, 2);
        step(1'b1, 1'b0, 1'b0);
`ifdef CTRL_OVF_TRAP_EN
        exp_cause = 3'd1;
        expect_o("addi.exc", O_STATE, 16);
        expect_o("addi.exc_pcsrc", O_PCSRC, 3);
        expect_o("addi.exc_epcw", O_EPCW, 1);
        expect_o("addi.exc_causew", O_CAUSEW, 1);
        expect_o("addi.exc_cause", O_CAUSE, 1);
        expect_o("addi.exc_regw", O_REGWRITE, 0);
`else
        expect_o("addi.wb", O_STATE, 11);
        expect_o("addi.wb_regw", O_REGWRITE, 1);
        expect_o("addi.wb_cause", O_CAUSE, 0);
`endif
        step(1'b1, 1'b1, 1'b0);
        expect_if("addi.if");
        step(1'b1, 1'b0, 1'b0);

        // lw with ready held low until the timeout fires
        fetch_decode("lw_to", 32'h8C22_0004);
        expect_o("lw_to.ex", O_STATE, 2);
        expect_o("lw_to.ex_srcb", O_ALUSRCB, 2);
        step(1'b1, 1'b0, 1'b0);
        expect_o("lw_to.rd", O_STATE, 3);
        expect_o("lw_to.rd_memrd", O_MEMREAD, 1);
        expect_o("lw_to.rd_iord", O_IORD, 1);
        step(1'b0, 1'b0, 1'b0);
        wait_mem_rd("lw_to");
        exp_cause = 3'd2;
        expect_o("lw_to.exc", O_STATE, 16);
        expect_o("lw_to.exc_cause", O_CAUSE, 2);
        expect_o("lw_to.exc_pcsrc", O_PCSRC, 3);
        expect_o("lw_to.exc_pcw", O_PCWRITE, 1);
        step(1'b0, 1'b0, 1'b0);
        expect_if("lw_to.if");
        step(1'b0, 1'b0, 1'b0);

        // lw with ready arriving on the limit cycle
        fetch_decode("lw_ok", 32'h8C22_0004);
        expect_o("lw_ok.ex", O_STATE, 2);
        step(1'b1, 1'b0, 1'b0);
        expect_o("lw_ok.rd", O_STATE, 3);
        step(1'b0, 1'b0, 1'b0);
        wait_mem_rd("lw_ok");
        expect_o("lw_ok.wb", O_STATE, 4);
        expect_o("lw_ok.wb_regw", O_REGWRITE, 1);
        expect_o("lw_ok.wb_m2r", O_MEMTOREG, 1);
        expect_o("lw_ok.wb_cause", O_CAUSE, 2);
        step(1'b1, 1'b0, 1'b0);
        expect_if("lw_ok.if");
        step(1'b1, 1'b0, 1'b0);

        // illegal opcode, then illegal R-type funct
        fetch_decode("ill_op", 32'hFC00_0000);
        exp_cause = 3'd3;
        expect_o("ill_op.exc", O_STATE, 16);
        expect_o("ill_op.exc_cause", O_CAUSE, 3);
        expect_o("ill_op.exc_causew", O_CAUSEW, 1);
        expect_o("ill_op.exc_epcw", O_EPCW, 1);
        step(1'b1, 1'b0, 1'b0);
        expect_if("ill_op.if");
        expect_o("ill_op.if_causew", O_CAUSEW, 0);
        step(1'b1, 1'b0, 1'b0);
        fetch_decode("ill_fn", 32'h0000_003F);
        expect_o("ill_fn.exc", O_STATE, 16);
        expect_o("ill_fn.exc_cause", O_CAUSE, 3);
        step(1'b1, 1'b0, 1'b0);
        expect_if("ill_fn.if");
        step(1'b1, 1'b0, 1'b0);

        // beq with zero=1, bne with zero=0
        fetch_decode("beq", 32'h1022_0003);
        expect_o("beq.br", O_STATE, 8);
        expect_o("beq.pcwc", O_PCWCOND, 1);
        expect_o("beq.pcsrc", O_PCSRC, 1);
        expect_o("beq.branch", O_BRANCH, 1);
        expect_o("beq.alu", O_ALUOP, 4'b0110);
        step(1'b1, 1'b0, 1'b1);
        expect_if("beq.if");
        step(1'b1, 1'b0, 1'b1);
        fetch_decode("bne", 32'h1422_0003);
        expect_o("bne.br", O_STATE, 8);
        expect_o("bne.pcwc", O_PCWCOND, 1);
        expect_o("bne.pcsrc", O_PCSRC, 1);
        expect_o("bne.branch", O_BRANCH, 0);
        step(1'b1, 1'b0, 1'b0);
        expect_if("bne.if");
        expect_o("bne.if_pcwc", O_PCWCOND, 0);
        step(1'b1, 1'b0, 1'b0);

        // jumps and lui
        fetch_decode("j", 32'h0800_0010);
        expect_o("j.st", O_STATE, 9);
        expect_o("j.pcsrc", O_PCSRC, 2);
        expect_o("j.pcw", O_PCWRITE, 1);
        step(1'b1, 1'b0, 1'b0);
        expect_if("j.if");
        step(1'b1, 1'b0, 1'b0);
        fetch_decode("jal", 32'h0C00_0010);
        expect_o("jal.st", O_STATE, 15);
        expect_o("jal.regdst", O_REGDST, 2);
        expect_o("jal.m2r", O_MEMTOREG, 3);
        expect_o("jal.regw", O_REGWRITE, 1);
        step(1'b1, 1'b0, 1'b0);
        expect_if("jal.if");
        step(1'b1, 1'b0, 1'b0);
        fetch_decode("jr", 32'h03E0_0008);
        expect_o("jr.st", O_STATE, 14);
        expect_o("jr.pcw", O_PCWRITE, 1);
        expect_o("jr.pcsrc", O_PCSRC, 0);
        step(1'b1, 1'b0, 1'b0);
        expect_if("jr.if");
        step(1'b1, 1'b0, 1'b0);
        fetch_decode("lui", 32'h3C01_1234);
        expect_o("lui.st", O_STATE, 12);
        expect_o("lui.m2r", O_MEMTOREG, 2);
        expect_o("lui.regw", O_REGWRITE, 1);
        step(1'b1, 1'b0, 1'b0);
        expect_if("lui.if");
        step(1'b1, 1'b0, 1'b0);

        // sw interrupted by reset while waiting in MEM_WR
        fetch_decode("sw", 32'hAC22_0004);
        expect_o("sw.ex", O_STATE, 2);
        step(1'b1, 1'b0, 1'b0);
        expect_o("sw.wr", O_STATE, 5);
        expect_o("sw.wr_memw", O_MEMWRITE, 1);
        step(1'b0, 1'b0, 1'b0);
        expect_o("sw.wr_hold", O_STATE, 5);
        expect_o("sw.wr_hold_memw", O_MEMWRITE, 1);
        step(1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        exp_cause = 3'd0;
        expect_o("sw.rst_memw", O_MEMWRITE, 0);
        expect_o("sw.rst_state", O_STATE, 0);
        expect_o("sw.rst_cause", O_CAUSE, 0);
        expect_o("sw.rst_regw", O_REGWRITE, 0);
        check();
        @(negedge clk);
        reset = 1'b1;
        expect_if("sw.if");
        step(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
